frog_game_ctrl: RTL
===================

# frog_game_ctrl

Game-state sequencer for the frog VGA game. Samples per-pixel collision and goal events across each video frame, runs the PLAY/DEAD/WIN/GAMEOVER state machine, and times the full-screen result displays in frames. It also tracks lives and level, and drives the colour-mux mode, frog respawn and hazard freeze. It sits between the square/frog animators and the VGA colour register stage in `top`.

## Interface

Parameters:
- `HOLD_FRAMES`, default 180: number of frames the DEAD/WIN screen is held (3 s at 60 Hz).
- `LIVES`, default 3: lives at game start, range 1..7.
- `MAX_LEVEL`, default 7: level saturation value, range 1..7.

Ports:
- `i_clk`, in, 1: system clock, 100 MHz.
- `i_rst`, in, 1: synchronous, active-high reset.
- `i_animate`, in, 1: one-cycle end-of-frame pulse from `vga640x480`.
- `i_hit`, in, 1: frog pixel overlaps a hazard pixel this cycle.
- `i_win`, in, 1: frog has reached the goal row; level-sensitive.
- `i_start`, in, 1: restart request from any button; level-sensitive.
- `o_mode`, out, 2: 0 PLAY, 1 DEAD, 2 WIN, 3 GAMEOVER.
- `o_frog_rst`, out, 1: one-cycle pulse that returns the frog to its spawn position.
- `o_freeze`, out, 1: holds all animators still.
- `o_lives`, out, 3: lives remaining.
- `o_level`, out, 3: current level, 1-based; drives hazard speed.

## Operation

- Hit accumulator `hit_acc`:
  - Set by `i_hit` while in PLAY.
  - Evaluated on each `i_animate` cycle as `hit_acc | i_hit`, so a hit in the pulse cycle counts.
  - Cleared in that same evaluation cycle.
  - Held clear in every state other than PLAY.
- State transitions, evaluated only on `i_animate`:
  - PLAY, hit: lives decrement. Go to GAMEOVER if lives become 0, otherwise to DEAD.
  - PLAY, no hit, `i_win`: go to WIN; level increments, saturating at `MAX_LEVEL`.
  - Hit and win in the same frame: hit takes priority; level is unchanged.
  - DEAD or WIN: frame counter increments each frame. When the count reaches `HOLD_FRAMES-1`, go to PLAY and clear the counter.
  - GAMEOVER: frame counter saturates at `HOLD_FRAMES-1`. Once saturated, `i_start` is sampled on `i_animate`; if high, go to PLAY with lives = `LIVES` and level = 1.
- `o_frog_rst` pulses on every entry to PLAY from DEAD, WIN or GAMEOVER, and for the one cycle after reset deasserts.
- `o_freeze` = (`o_mode` != PLAY).
- Arithmetic: the frame counter is `$clog2(HOLD_FRAMES)` bits wide, with an 8-bit minimum. Lives decrement never wraps below 0. Level increment never exceeds `MAX_LEVEL`.

## Timing

- All outputs are registered.
- Reset values: `o_mode`=0, `o_frog_rst`=0, `o_freeze`=0, `o_lives`=`LIVES`, `o_level`=1, `hit_acc`=0, counter=0.
- Latency: `o_mode`, `o_lives` and `o_level` update the cycle after the qualifying `i_animate` cycle. `o_frog_rst` is high for exactly that cycle. `o_freeze` follows `o_mode` in the same cycle.
- Events without `i_animate` never change state. This includes `i_win` or `i_start` pulses that fall between frames.
- Reset asserted mid-hold or in GAMEOVER returns to reset values on the next edge. Any partial count is discarded.
- `i_hit` during DEAD, WIN or GAMEOVER is ignored and does not carry into the next PLAY frame.

## Configuration

- `FROG_LIVES_EN` defined:
  - Lives counter and GAMEOVER are present, as described above.
- `FROG_LIVES_EN` undefined:
  - Lives are infinite and GAMEOVER is unreachable; a hit always goes to DEAD.
  - `o_lives` is tied to `LIVES`, and `i_start` is ignored.
  - The lives register is not synthesised.

## Structure

- Shared package `frog_pkg`:
  - Mode encodings `MODE_PLAY`, `MODE_DEAD`, `MODE_WIN`, `MODE_OVER`.
  - Default `HOLD_FRAMES`.
  - The `top` colour mux uses the same constants.
- One sub-module, `frame_timer`:
  - Frame-counting hold timer, with inputs `i_clk`, `i_rst`, `i_tick` (= `i_animate`) and `i_clr`.
  - Output `o_done` when the count reaches `HOLD_FRAMES-1`; the count saturates there.
  - Instantiated once and reused for DEAD, WIN and GAMEOVER.

## Test plan

Benches use `HOLD_FRAMES`=4, `LIVES`=2, `MAX_LEVEL`=3, with `i_animate` every 100 cycles.

- Hit then hold: one-cycle `i_hit` mid-frame → after next `i_animate`, `o_mode`=1, `o_lives`=1, `o_freeze`=1; after 4 further frames, `o_mode`=0 with a single `o_frog_rst` pulse.
- Coincident events: `i_hit` in the same cycle as `i_animate` → DEAD. `i_hit` and `i_win` in the same frame → DEAD, `o_level` stays 1.
- Level saturation: three wins, each completing its hold → `o_level` goes 2, 3, 3.
- Game over: two hits → `o_mode`=3, `o_lives`=0. `i_start` before 4 frames → ignored. `i_start` after 4 frames → `o_mode`=0, `o_lives`=2, `o_level`=1.
- Reset mid-hold: `i_rst` during frame 2 of DEAD → next cycle all reset values. No DEAD→PLAY `o_frog_rst` pulse occurs; only the single post-reset pulse fires after `i_rst` deasserts.
- Without `FROG_LIVES_EN`: five hits → `o_mode` never 3, `o_lives` constant at 2.

Source files
------------

// File: rtl/frog_pkg.sv
// Shared constants for the frog VGA game: colour-mux mode encodings, the
// default result-screen hold length and a counter-width helper.
package frog_pkg;

   typedef logic [1:0] mode_t;

   // Colour-mux modes, shared with the colour mux in top
   localparam mode_t MODE_PLAY = 2'd0;
   localparam mode_t MODE_DEAD = 2'd1;
   localparam mode_t MODE_WIN  = 2'd2;
   localparam mode_t MODE_OVER = 2'd3;

   // 3 s at 60 frames per second
   localparam int HOLD_FRAMES_DEF = 180;

   // Frame counter width: enough for hold-1, never narrower than 8 bits
   function automatic int cnt_width(input int hold);
      return ($clog2(hold) > 8) ? $clog2(hold) : 8;
   endfunction

endpackage

// File: rtl/frog_game_ctrl_frame_timer.sv
// frame_timer: counts end-of-frame ticks up to HOLD_FRAMES-1 and saturates
// there. Shared by the DEAD, WIN and GAMEOVER result screens.
module frame_timer
   import frog_pkg::*;
#(
   parameter int HOLD_FRAMES = HOLD_FRAMES_DEF
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_tick,
   input  logic i_clr,
   output logic o_done
);

   localparam int             CW   = cnt_width(HOLD_FRAMES);
   localparam logic [CW-1:0]  LAST = CW'(HOLD_FRAMES - 1);

   logic [CW-1:0] count;

   // Saturating frame count; a clear discards any partial count
   always_ff @(posedge i_clk) begin
      // NOTE: registered state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      if (i_rst || i_clr) begin
         count <= '0;
      end else if (i_tick && (count != LAST)) begin
         count <= count + 1'b1;
      end
   end

   assign o_done = (count == LAST);

endmodule

// File: rtl/frog_game_ctrl.sv
// frog_game_ctrl: game-state sequencer for the frog VGA game.
// Accumulates per-pixel hits over a frame, steps PLAY/DEAD/WIN/GAMEOVER on
// each end-of-frame pulse, and tracks lives and level.
// Build option: define FROG_LIVES_EN to enable the lives counter and the
// GAMEOVER screen; without it lives are infinite and o_lives is fixed.
module frog_game_ctrl
   import frog_pkg::*;
#(
   parameter int HOLD_FRAMES = HOLD_FRAMES_DEF,
   parameter int LIVES       = 3,
   parameter int MAX_LEVEL   = 7
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_animate,
   input  logic       i_hit,
   input  logic       i_win,
   input  logic       i_start,
   output logic [1:0] o_mode,
   output logic       o_frog_rst,
   output logic       o_freeze,
   output logic [2:0] o_lives,
   output logic [2:0] o_level
);

   localparam logic [2:0] LIVES_INIT = 3'(LIVES);
   localparam logic [2:0] LEVEL_MAX  = 3'(MAX_LEVEL);

   mode_t      mode_q, mode_d;
   logic [2:0] level_q, level_d;
   logic       hit_acc;
   logic       hit_now;
   logic       enter_play;
   logic       frog_rst_q;
   logic       post_rst_q;
   logic       freeze_q;
   logic       timer_done;
   logic       timer_clr;

`ifdef FROG_LIVES_EN
   logic [2:0] lives_q, lives_d;
`else
   logic       unused_start;
   assign unused_start = i_start;
`endif

   // A hit in the end-of-frame cycle itself still counts for that frame
   assign hit_now = hit_acc | i_hit;

   // Held clear during PLAY so each result screen starts from zero
   assign timer_clr = (mode_q == MODE_PLAY) | enter_play;

   frame_timer #(
      .HOLD_FRAMES (HOLD_FRAMES)
   ) u_frame_timer (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_tick (i_animate),
      .i_clr  (timer_clr),
      .o_done (timer_done)
   );

   // Next-state decode; nothing moves except on the end-of-frame pulse
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a signal unassigned and no latch is inferred.
      mode_d     = mode_q;
      level_d    = level_q;
      enter_play = 1'b0;
`ifdef FROG_LIVES_EN
      lives_d    = lives_q;
`endif
      if (i_animate) begin
         case (mode_q)
            MODE_PLAY: begin
               if (hit_now) begin
`ifdef FROG_LIVES_EN
                  lives_d = (lives_q != 3'd0) ? lives_q - 1'b1 : 3'd0;
                  mode_d  = (lives_d == 3'd0) ? MODE_OVER : MODE_DEAD;
`else
                  mode_d  = MODE_DEAD;
`endif
               end else if (i_win) begin
                  mode_d  = MODE_WIN;
                  level_d = (level_q >= LEVEL_MAX) ? LEVEL_MAX : level_q + 1'b1;
               end
            end
            MODE_DEAD, MODE_WIN: begin
               if (timer_done) begin
                  mode_d     = MODE_PLAY;
                  enter_play = 1'b1;
               end
            end
            MODE_OVER: begin
`ifdef FROG_LIVES_EN
               if (timer_done && i_start) begin
                  mode_d     = MODE_PLAY;
                  lives_d    = LIVES_INIT;
                  level_d    = 3'd1;
                  enter_play = 1'b1;
               end
`endif
            end
            default: mode_d = MODE_PLAY;
         endcase
      end
   end

   // Mode, level, hit accumulator and the registered strobes
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         mode_q     <= MODE_PLAY;
         level_q    <= 3'd1;
         hit_acc    <= 1'b0;
         freeze_q   <= 1'b0;
         frog_rst_q <= 1'b0;
         post_rst_q <= 1'b1;
      end else begin
         mode_q     <= mode_d;
         level_q    <= level_d;
         hit_acc    <= (mode_q == MODE_PLAY) && !i_animate && hit_now;
         freeze_q   <= (mode_d != MODE_PLAY);
         frog_rst_q <= enter_play | post_rst_q;
         post_rst_q <= 1'b0;
      end
   end

`ifdef FROG_LIVES_EN
   // Lives register, present only when the lives feature is built in
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         lives_q <= LIVES_INIT;
      end else begin
         lives_q <= lives_d;
      end
   end

   assign o_lives = lives_q;
`else
   assign o_lives = LIVES_INIT;
`endif

   assign o_mode     = mode_q;
   assign o_level    = level_q;
   assign o_freeze   = freeze_q;
   assign o_frog_rst = frog_rst_q;

endmodule
